// File: rtl/lsu_pkg.sv
// Shared types and the byte-lane mask helper for the load/store unit.
// The lane mask spans two bus beats so a misaligned access shows up as upper-half bits.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int MASK_W = 16;

    function automatic logic [MASK_W-1:0] byte_mask(input size_e size, input logic [2:0] off);
        logic [MASK_W-1:0] base;
        case (size)
            SZ_B:    base = 16'h0001;
            SZ_H:    base = 16'h0003;
            SZ_W:    base = 16'h000F;
            default: base = 16'h00FF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/data shift and load extract with sign/zero extension.
// LSU_MISALIGN_EN adds the second-beat (upper half) datapath.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]       st_size,
    input  logic [OFF_W-1:0] st_off,
    input  logic [XLEN-1:0]  st_wdata,
    output logic [NB-1:0]    st_be_lo,
    output logic [XLEN-1:0]  st_wdata_lo,
    output logic             st_split,
`ifdef LSU_MISALIGN_EN
    output logic [NB-1:0]    st_be_hi,
    output logic [XLEN-1:0]  st_wdata_hi,
    input  logic [XLEN-1:0]  ld_rdata_hi,
`endif
    input  logic [1:0]       ld_size,
    input  logic [OFF_W-1:0] ld_off,
    input  logic             ld_unsigned,
    input  logic [XLEN-1:0]  ld_rdata_lo,
    output logic [XLEN-1:0]  ld_data
);

    localparam int MW = 2 * NB;

    logic [MW-1:0]   mask;
    logic [XLEN-1:0] ld_window;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] top_bit;
    logic [6:0]      ld_bits;
    logic            sign;
`ifdef LSU_MISALIGN_EN
    logic [2*XLEN-1:0] st_shift;
`endif

    // NOTE: every output gets a value on every path through always_comb, so no latch can be inferred.
    always_comb begin
        mask     = MW'(byte_mask(size_e'(st_size), 3'(st_off)));
        st_be_lo = mask[NB-1:0];
        st_split = |mask[MW-1:NB];
`ifdef LSU_MISALIGN_EN
        st_be_hi    = mask[MW-1:NB];
        st_shift    = {{XLEN{1'b0}}, st_wdata} << {st_off, 3'b000};
        st_wdata_lo = st_shift[XLEN-1:0];
        st_wdata_hi = st_shift[2*XLEN-1:XLEN];
        ld_window   = XLEN'({ld_rdata_hi, ld_rdata_lo} >> {ld_off, 3'b000});
`else
        st_wdata_lo = st_wdata << {st_off, 3'b000};
        ld_window   = ld_rdata_lo >> {ld_off, 3'b000};
`endif
        // keep covers the loaded bytes; its MSB marks the sign bit of the loaded value
        ld_bits = 7'd8 << ld_size;
        keep    = ~({XLEN{1'b1}} << ld_bits);
        top_bit = keep & ~(keep >> 1);
        sign    = ~ld_unsigned & (|(ld_window & top_bit));
        ld_data = (ld_window & keep) | ({XLEN{sign}} & ~keep);
    end

endmodule

// File: rtl/lsu_xlen.sv
// Load/store unit between execute and the single-beat d_* bus; one access in flight.
// Defining LSU_MISALIGN_EN splits misaligned accesses into two beats instead of rejecting them.
module lsu_xlen
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [4:0]          req_rd,
    output logic                resp_valid,
    output logic [4:0]          resp_rd,
    output logic [XLEN-1:0]     resp_data,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   d_addr,
    output logic                d_rd_req,
    output logic                d_wr_req,
    input  logic                d_rd_ready,
    input  logic                d_wr_ready,
    output logic [XLEN/8-1:0]   d_wr_be,
    output logic [XLEN-1:0]     d_wr_data,
    input  logic [XLEN-1:0]     d_rd_data
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_e           state;
    logic             store_q;
    logic             unsigned_q;
    logic [1:0]       size_q;
    logic [OFF_W-1:0] off_q;

    logic             accept;
    logic             size_err;
    logic             req_err;
    logic             beat_done;
    logic [NB-1:0]    be_lo;
    logic [XLEN-1:0]  wdata_lo;
    logic             split;
    logic [XLEN-1:0]  ld_data;
    logic [XLEN-1:0]  ld_rdata_lo;

`ifdef LSU_MISALIGN_EN
    logic             split_q;
    logic [NB-1:0]    be_hi;
    logic [NB-1:0]    be_hi_q;
    logic [XLEN-1:0]  wdata_hi;
    logic [XLEN-1:0]  wdata_hi_q;
    logic [XLEN-1:0]  rdata_lo_q;

    assign req_err     = size_err;
    assign ld_rdata_lo = (state == ST_BEAT1) ? rdata_lo_q : d_rd_data;
`else
    assign req_err     = size_err | split;
    assign ld_rdata_lo = d_rd_data;
`endif

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign size_err  = (req_size == SZ_D) && (XLEN == 32);
    assign beat_done = (d_rd_req && d_rd_ready) || (d_wr_req && d_wr_ready);

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_size     (req_size),
        .st_off      (req_addr[OFF_W-1:0]),
        .st_wdata    (req_wdata),
        .st_be_lo    (be_lo),
        .st_wdata_lo (wdata_lo),
        .st_split    (split),
`ifdef LSU_MISALIGN_EN
        .st_be_hi    (be_hi),
        .st_wdata_hi (wdata_hi),
        .ld_rdata_hi (d_rd_data),
`endif
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata_lo (ld_rdata_lo),
        .ld_data     (ld_data)
    );

    // NOTE: captured request fields are qualified by state, so they need no reset; only control and visible outputs are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            d_addr     <= '0;
            d_rd_req   <= 1'b0;
            d_wr_req   <= 1'b0;
            d_wr_be    <= '0;
            d_wr_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        store_q    <= req_store;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        off_q      <= req_addr[OFF_W-1:0];
                        resp_rd    <= req_rd;
`ifdef LSU_MISALIGN_EN
                        split_q    <= split;
                        be_hi_q    <= be_hi;
                        wdata_hi_q <= req_store ? wdata_hi : '0;
`endif
                        if (req_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= ST_BEAT0;
                            d_addr    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            d_rd_req  <= !req_store;
                            d_wr_req  <= req_store;
                            d_wr_be   <= be_lo;
                            d_wr_data <= req_store ? wdata_lo : '0;
                        end
                    end
                end
                ST_BEAT0, ST_BEAT1: begin
                    if (beat_done) begin
`ifdef LSU_MISALIGN_EN
                        if (state == ST_BEAT0 && split_q) begin
                            state      <= ST_BEAT1;
                            d_addr     <= d_addr + ADDR_W'(NB);
                            d_wr_be    <= be_hi_q;
                            d_wr_data  <= wdata_hi_q;
                            rdata_lo_q <= d_rd_data;
                        end else
`endif
                        begin
                            state      <= ST_RESP;
                            d_rd_req   <= 1'b0;
                            d_wr_req   <= 1'b0;
                            d_wr_be    <= '0;
                            d_wr_data  <= '0;
                            resp_valid <= 1'b1;
                            resp_data  <= store_q ? '0 : ld_data;
                        end
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_data  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_xlen.sv
// Bench for lsu_xlen (XLEN=32): table-driven accesses with a bus responder, a response
// scoreboard, and a hand-written reset-abort sequence; expectations follow LSU_MISALIGN_EN.
module tb_lsu_xlen;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    typedef struct {
        string            name;
        logic             store;
        logic [1:0]       size;
        logic             uns;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [1:0][31:0] rdata;
        int               delay;
        logic             err;
        int               beats;
        logic [1:0][31:0] b_addr;
        logic [1:0][3:0]  b_be;
        logic [1:0][31:0] b_wd;
        logic [31:0]      data;
        logic [4:0]       rd;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_store = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic [4:0]        req_rd = '0;
    logic              resp_valid;
    logic [4:0]        resp_rd;
    logic [XLEN-1:0]   resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] d_addr;
    logic              d_rd_req;
    logic              d_wr_req;
    logic              d_rd_ready = 1'b0;
    logic              d_wr_ready = 1'b0;
    logic [XLEN/8-1:0] d_wr_be;
    logic [XLEN-1:0]   d_wr_data;
    logic [XLEN-1:0]   d_rd_data = 32'h0BAD_F00D;

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t exp_q[$];
    vec_t  vecs[$];

    always #5 clk = ~clk;

    lsu_xlen #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_rd      (resp_rd),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .d_addr       (d_addr),
        .d_rd_req     (d_rd_req),
        .d_wr_req     (d_wr_req),
        .d_rd_ready   (d_rd_ready),
        .d_wr_ready   (d_wr_ready),
        .d_wr_be      (d_wr_be),
        .d_wr_data    (d_wr_data),
        .d_rd_data    (d_rd_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic store, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rd0, input logic [31:0] rd1, input int delay,
                                input logic err, input int beats,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [3:0] be0, input logic [3:0] be1,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                input logic [31:0] data);
        vec_t v;
        v.name = name; v.store = store; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.rdata[0] = rd0; v.rdata[1] = rd1;
        v.delay = delay; v.err = err; v.beats = beats;
        v.b_addr[0] = a0; v.b_addr[1] = a1; v.b_be[0] = be0; v.b_be[1] = be1;
        v.b_wd[0] = wd0; v.b_wd[1] = wd1; v.data = data; v.rd = 5'd0;
        return v;
    endfunction

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            check("sb_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                resp_t e;
                e = exp_q.pop_front();
                check("resp_rd", resp_rd, e.rd);
                check("resp_data", resp_data, e.data);
                check("resp_err", resp_err, e.err);
            end
        end
    end

    task automatic run(input vec_t v);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 16) begin
            @(negedge clk);
            budget++;
        end
        check({v.name, "/ready"}, req_ready, 1'b1);
        req_valid    = 1'b1;
        req_store    = v.store;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_rd       = v.rd;
        exp_q.push_back('{rd: v.rd, data: v.data, err: v.err});
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (v.err) begin
            check({v.name, "/err_no_bus"}, {d_rd_req, d_wr_req}, 2'b00);
            check({v.name, "/err_latency"}, resp_valid, 1'b1);
        end else begin
            for (int b = 0; b < v.beats; b++) begin
                int waits;
                waits = (b == 0) ? v.delay : 0;
                for (int w = 0; w <= waits; w++) begin
                    check({v.name, "/req"}, {d_rd_req, d_wr_req}, v.store ? 2'b01 : 2'b10);
                    check({v.name, "/addr"}, d_addr, v.b_addr[b]);
                    check({v.name, "/be"}, d_wr_be, v.b_be[b]);
                    check({v.name, "/wdata"}, d_wr_data, v.store ? v.b_wd[b] : 32'h0);
                    check({v.name, "/no_early_resp"}, resp_valid, 1'b0);
                    if (w == waits) begin
                        d_rd_ready = !v.store;
                        d_wr_ready = v.store;
                        d_rd_data  = v.rdata[b];
                    end
                    @(negedge clk);
                    d_rd_ready = 1'b0;
                    d_wr_ready = 1'b0;
                    d_rd_data  = $urandom;
                end
            end
            check({v.name, "/latency"}, resp_valid, 1'b1);
            check({v.name, "/bus_idle"}, {d_rd_req, d_wr_req, d_wr_be}, 6'd0);
        end
        check({v.name, "/busy_in_resp"}, req_ready, 1'b0);
        @(negedge clk);
        check({v.name, "/reready"}, req_ready, 1'b1);
        check({v.name, "/single_pulse"}, resp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back(mk("lw_aligned", 0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 1, 32'h100, 0, 4'hF, 0, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk("lb_sign", 0, 2'd0, 0, 32'h103, 0, 32'h80123456, 0, 0, 0, 1, 32'h100, 0, 4'h8, 0, 0, 0, 32'hFFFFFF80));
        vecs.push_back(mk("lbu_zero", 0, 2'd0, 1, 32'h103, 0, 32'h80123456, 0, 1, 0, 1, 32'h100, 0, 4'h8, 0, 0, 0, 32'h00000080));
        vecs.push_back(mk("sh_wait3", 1, 2'd1, 0, 32'h202, 32'h1234, 0, 0, 3, 0, 1, 32'h200, 0, 4'hC, 0, 32'h12340000, 0, 0));
        vecs.push_back(mk("lh_sign", 0, 2'd1, 0, 32'h102, 0, 32'h80015555, 0, 0, 0, 1, 32'h100, 0, 4'hC, 0, 0, 0, 32'hFFFF8001));
        vecs.push_back(mk("lhu_zero", 0, 2'd1, 1, 32'h102, 0, 32'h80015555, 0, 0, 0, 1, 32'h100, 0, 4'hC, 0, 0, 0, 32'h00008001));
        vecs.push_back(mk("sb_lane1", 1, 2'd0, 0, 32'h101, 32'hFFFFFFAB, 0, 0, 0, 0, 1, 32'h100, 0, 4'h2, 0, 32'hFFFFAB00, 0, 0));
        vecs.push_back(mk("sw_wait1", 1, 2'd2, 0, 32'h10, 32'hCAFEF00D, 0, 0, 1, 0, 1, 32'h10, 0, 4'hF, 0, 32'hCAFEF00D, 0, 0));
        vecs.push_back(mk("lb_pos", 0, 2'd0, 0, 32'h0, 0, 32'h1234567F, 0, 0, 0, 1, 32'h0, 0, 4'h1, 0, 0, 0, 32'h0000007F));
        vecs.push_back(mk("size3_err", 0, 2'd3, 0, 32'h40, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef LSU_MISALIGN_EN
        vecs.push_back(mk("lw_wrap_split", 0, 2'd2, 0, 32'hFFFFFFFE, 0, 32'h5678AAAA, 32'hBBBB1234, 2, 0, 2, 32'hFFFFFFFC, 32'h0, 4'hC, 4'h3, 0, 0, 32'h12345678));
        vecs.push_back(mk("lh_split", 0, 2'd1, 0, 32'h103, 0, 32'h11223344, 32'h55667788, 0, 0, 2, 32'h100, 32'h104, 4'h8, 4'h1, 0, 0, 32'hFFFF8811));
        vecs.push_back(mk("sw_split", 1, 2'd2, 0, 32'h201, 32'hA1B2C3D4, 0, 0, 1, 0, 2, 32'h200, 32'h204, 4'hE, 4'h1, 32'hB2C3D400, 32'h000000A1, 0));
`else
        vecs.push_back(mk("lw_wrap_err", 0, 2'd2, 0, 32'hFFFFFFFE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lh_mis_err", 0, 2'd1, 0, 32'h103, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sw_mis_err", 1, 2'd2, 0, 32'h201, 32'hA1B2C3D4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst/req_ready", req_ready, 1'b0);
        check("rst/resp", {resp_valid, resp_err, resp_data}, 34'd0);
        check("rst/bus", {d_rd_req, d_wr_req, d_wr_be}, 6'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst/ready_after", req_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            v.rd = 5'(i + 1);
            run(v);
        end

        // Reset while a read beat is waiting on d_rd_ready
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h300; req_rd = 5'd30;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort/rd_req", d_rd_req, 1'b1);
        @(negedge clk);
        check("abort/rd_req_held", {d_rd_req, d_addr}, {1'b1, 32'h300});
        rst = 1'b1;
        @(negedge clk);
        check("abort/outputs", {resp_valid, resp_err, resp_data, d_rd_req, d_wr_req, d_wr_be, d_addr, d_wr_data},
              {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
        check("abort/ready_in_rst", req_ready, 1'b0);
        rst = 1'b0;
        d_rd_ready = 1'b1;
        @(negedge clk);
        d_rd_ready = 1'b0;
        check("abort/ready_after", req_ready, 1'b1);
        check("abort/no_resp", resp_valid, 1'b0);
        @(negedge clk);
        check("abort/still_no_resp", resp_valid, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
